// File: rtl/magic_nmi_ctrl_pkg.sv
// Shared types for the magic/pause NMI front-end.
package magic_nmi_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_MAGIC = 2'd1,
    SRC_PAUSE = 2'd2
  } magic_src_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/magic_nmi_ctrl_if.sv
// Board-side inputs and magic-logic-side outputs of the NMI front-end.
interface magic_nmi_ctrl_if;
  import magic_nmi_ctrl_pkg::*;

  logic       magic_btn_raw;
  logic       pause_btn_raw;
  logic       n_int;
  logic       n_int_next;
  logic       div_paged;
  logic       magic_mode;
  logic       magic_button;
  logic       pause_button;
  logic       magic_db;
  logic       pause_db;
  magic_src_t req_src;
  logic       reboot_req;
  logic       busy;
  logic       timeout;

  modport master (
    output magic_btn_raw, pause_btn_raw, n_int, n_int_next, div_paged, magic_mode,
    input  magic_button, pause_button, magic_db, pause_db, req_src, reboot_req,
           busy, timeout
  );

  modport slave (
    input  magic_btn_raw, pause_btn_raw, n_int, n_int_next, div_paged, magic_mode,
    output magic_button, pause_button, magic_db, pause_db, req_src, reboot_req,
           busy, timeout
  );

endinterface

// File: rtl/magic_nmi_ctrl_debounce.sv
// Two-flop synchroniser plus stability counter; press_o pulses when db rises.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 28000,
  parameter int DEBOUNCE_W      = 15
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic press_o
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q, sync2_q;
  logic                  db_q, db_d;
  logic                  press_q;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = sync2_q;
      else                  cnt_d = cnt_q + DEBOUNCE_W'(1);
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= db_d & ~db_q;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/magic_nmi_ctrl.sv
// Magic/pause NMI front-end: debounce, arbitrate, frame-align the request,
// supervise the magic_mode handshake and flag long magic presses as reboot.
module magic_nmi_ctrl
  import magic_nmi_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 28000,
  parameter int DEBOUNCE_W        = 15,
  parameter int LONG_PRESS_FRAMES = 100,
  parameter int TIMEOUT_FRAMES    = 8
) (
  input logic             clk28,
  input logic             rst_n,
  magic_nmi_ctrl_if.slave bus
);

  localparam int TO_W = cnt_w(TIMEOUT_FRAMES);
  localparam int LP_W = cnt_w(LONG_PRESS_FRAMES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_FRAMES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_FRAMES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, ASSERT, WAIT_EXIT} state_t;

  state_t           state_q, state_d;
  magic_src_t       src_q, src_d;
  logic [TO_W-1:0]  fcnt_q, fcnt_d;
  logic             timeout_q, timeout_d;
  logic [LP_W-1:0]  lp_q, lp_d;
  logic             reboot_q, reboot_d;
  logic             magic_db, pause_db, magic_press, pause_press;
  logic             frame_tick;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)) u_db_magic (
    .clk28(clk28), .rst_n(rst_n), .raw_i(bus.magic_btn_raw),
    .db_o(magic_db), .press_o(magic_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)) u_db_pause (
    .clk28(clk28), .rst_n(rst_n), .raw_i(bus.pause_btn_raw),
    .db_o(pause_db), .press_o(pause_press)
  );

  assign frame_tick = bus.n_int & ~bus.n_int_next;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    fcnt_d    = fcnt_q;
    timeout_d = timeout_q;
    if (magic_press || pause_press) timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        src_d = SRC_NONE;
        if (magic_press) begin
          src_d   = SRC_MAGIC;
          state_d = PENDING;
        end else if (pause_press) begin
          src_d   = SRC_PAUSE;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (magic_press) src_d = SRC_MAGIC;
        // Already in magic mode: nothing to request, just wait for it to end.
        if (bus.magic_mode) state_d = WAIT_EXIT;
        else if (frame_tick && !bus.div_paged) begin
          state_d = ASSERT;
          fcnt_d  = '0;
        end
      end
      ASSERT: begin
        if (bus.magic_mode) state_d = WAIT_EXIT;
        else if (frame_tick) begin
          if (fcnt_q == TO_LAST) begin
            state_d   = IDLE;
            src_d     = SRC_NONE;
            timeout_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + TO_W'(1);
          end
        end
      end
      WAIT_EXIT: begin
        if (!bus.magic_mode && !magic_db && !pause_db) begin
          state_d = IDLE;
          src_d   = SRC_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Long-press tracker runs regardless of the request FSM.
  always_comb begin
    lp_d     = lp_q;
    reboot_d = 1'b0;
    if (!magic_db) lp_d = '0;
    else if (frame_tick && lp_q != LP_MAX) begin
      lp_d     = lp_q + LP_W'(1);
      reboot_d = (lp_q == LP_LAST);
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= SRC_NONE;
      fcnt_q    <= '0;
      timeout_q <= 1'b0;
      lp_q      <= '0;
      reboot_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      fcnt_q    <= fcnt_d;
      timeout_q <= timeout_d;
      lp_q      <= lp_d;
      reboot_q  <= reboot_d;
    end
  end

  // Request drops combinationally on the acknowledge.
  assign bus.magic_button = (state_q == ASSERT) && (src_q == SRC_MAGIC) && !bus.magic_mode;
  assign bus.pause_button = (state_q == ASSERT) && (src_q == SRC_PAUSE) && !bus.magic_mode;
  assign bus.magic_db     = magic_db;
  assign bus.pause_db     = pause_db;
  assign bus.req_src      = src_q;
  assign bus.reboot_req   = reboot_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_magic_nmi_ctrl.sv
// Directed scenarios plus random button traffic for magic_nmi_ctrl.
module tb_magic_nmi_ctrl;
  import magic_nmi_ctrl_pkg::*;

  localparam int DC = 4;
  localparam int LP = 3;
  localparam int TO = 2;
  localparam int FP = 50;

  logic clk28;
  logic rst_n;
  int   checks, errors, phase, reboots, pause_seen;
  bit   hm[$], hp[$];
  bit   dbm_m, dbm_p;

  magic_nmi_ctrl_if bus();

  magic_nmi_ctrl #(
    .DEBOUNCE_CYCLES(DC), .DEBOUNCE_W(3),
    .LONG_PRESS_FRAMES(LP), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .bus(bus)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_src(input string tag, input magic_src_t obs, input magic_src_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs.name(), exp.name());
    end
  endtask

  // Debounced level flips once the input (seen two cycles late through the
  // synchroniser) has disagreed with it for DC consecutive samples.
  function automatic bit win_flip(input bit h[$], input bit db);
    for (int i = 0; i < DC; i++) if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mdl_reset();
    hm = {};
    hp = {};
    for (int i = 0; i < DC + 2; i++) begin
      hm.push_back(1'b0);
      hp.push_back(1'b0);
    end
    dbm_m = 1'b0;
    dbm_p = 1'b0;
  endtask

  task automatic step();
    bit rm, rp, rr;
    @(posedge clk28);
    rm = bus.magic_btn_raw;
    rp = bus.pause_btn_raw;
    rr = rst_n;
    #1;
    if (!rr) mdl_reset();
    else begin
      hm.push_back(rm); void'(hm.pop_front());
      hp.push_back(rp); void'(hp.pop_front());
      if (win_flip(hm, dbm_m)) dbm_m = ~dbm_m;
      if (win_flip(hp, dbm_p)) dbm_p = ~dbm_p;
    end
    chk("magic_db_model", bus.magic_db, dbm_m);
    chk("pause_db_model", bus.pause_db, dbm_p);
    chk("one_request_at_a_time", bus.magic_button & bus.pause_button, 1'b0);
    if (bus.reboot_req) reboots++;
    if (bus.pause_button) pause_seen++;
    phase = (phase + 1) % FP;
    bus.n_int_next = (phase != FP - 1);
    bus.n_int      = (phase != 0);
  endtask

  // Runs through the next frame_tick edge; returns one cycle after it.
  task automatic cross_tick();
    while (phase != FP - 1) step();
    step();
  endtask

  initial begin
    checks = 0; errors = 0; phase = 1; reboots = 0; pause_seen = 0;
    rst_n = 1'b0;
    bus.magic_btn_raw = 1'b0; bus.pause_btn_raw = 1'b0;
    bus.n_int = 1'b1; bus.n_int_next = 1'b1;
    bus.div_paged = 1'b0; bus.magic_mode = 1'b0;
    mdl_reset();

    // Reset state
    repeat (3) step();
    chk("rst_magic_button", bus.magic_button, 1'b0);
    chk("rst_pause_button", bus.pause_button, 1'b0);
    chk("rst_reboot", bus.reboot_req, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk_src("rst_req_src", bus.req_src, SRC_NONE);
    rst_n = 1'b1;

    // Debounce: 3-cycle glitch ignored, then a held press lands after 6 cycles
    cross_tick();
    bus.magic_btn_raw = 1'b1;
    repeat (3) step();
    bus.magic_btn_raw = 1'b0;
    repeat (8) step();
    chk("glitch_db", bus.magic_db, 1'b0);
    chk("glitch_busy", bus.busy, 1'b0);
    bus.magic_btn_raw = 1'b1;
    repeat (5) step();
    chk("db_at_5", bus.magic_db, 1'b0);
    step();
    chk("db_at_6", bus.magic_db, 1'b1);
    step();
    chk("pending_busy", bus.busy, 1'b1);
    chk_src("pending_src", bus.req_src, SRC_MAGIC);
    chk("pending_no_req", bus.magic_button, 1'b0);

    // Normal entry and handshake
    cross_tick();
    chk("entry_magic_button", bus.magic_button, 1'b1);
    chk("entry_pause_button", bus.pause_button, 1'b0);
    repeat (3) step();
    chk("entry_held", bus.magic_button, 1'b1);
    bus.magic_mode = 1'b1;
    #1;
    chk("ack_drop_same_cycle", bus.magic_button, 1'b0);
    step();
    chk("wait_exit_busy", bus.busy, 1'b1);
    chk("wait_exit_no_req", bus.magic_button, 1'b0);
    bus.magic_mode = 1'b0;
    bus.magic_btn_raw = 1'b0;
    repeat (5) step();
    chk("wait_exit_until_release", bus.busy, 1'b1);
    repeat (2) step();
    chk("exit_idle", bus.busy, 1'b0);
    chk_src("exit_src", bus.req_src, SRC_NONE);

    // Deferral while DivMMC is paged
    cross_tick();
    bus.div_paged = 1'b1;
    bus.pause_btn_raw = 1'b1;
    repeat (7) step();
    bus.pause_btn_raw = 1'b0;
    chk_src("defer_src", bus.req_src, SRC_PAUSE);
    cross_tick();
    chk("defer_tick1", bus.pause_button, 1'b0);
    chk("defer_busy", bus.busy, 1'b1);
    cross_tick();
    chk("defer_tick2", bus.pause_button, 1'b0);
    bus.div_paged = 1'b0;
    cross_tick();
    chk("defer_release", bus.pause_button, 1'b1);
    chk("defer_no_magic", bus.magic_button, 1'b0);
    bus.magic_mode = 1'b1;
    #1;
    chk("defer_ack_drop", bus.pause_button, 1'b0);
    step();
    bus.magic_mode = 1'b0;
    step();
    chk("defer_idle", bus.busy, 1'b0);

    // Arbitration: simultaneous press, magic wins
    cross_tick();
    pause_seen = 0;
    bus.magic_btn_raw = 1'b1;
    bus.pause_btn_raw = 1'b1;
    repeat (7) step();
    bus.magic_btn_raw = 1'b0;
    bus.pause_btn_raw = 1'b0;
    chk_src("arb_src", bus.req_src, SRC_MAGIC);
    cross_tick();
    chk("arb_magic_button", bus.magic_button, 1'b1);
    bus.magic_mode = 1'b1;
    step();
    bus.magic_mode = 1'b0;
    step();
    chk("arb_idle", bus.busy, 1'b0);
    chk("arb_pause_never", pause_seen == 0, 1'b1);

    // Upgrade in PENDING, then timeout
    cross_tick();
    bus.pause_btn_raw = 1'b1;
    repeat (7) step();
    chk_src("upg_before", bus.req_src, SRC_PAUSE);
    bus.magic_btn_raw = 1'b1;
    repeat (7) step();
    bus.magic_btn_raw = 1'b0;
    bus.pause_btn_raw = 1'b0;
    chk_src("upg_after", bus.req_src, SRC_MAGIC);
    cross_tick();
    chk("upg_assert", bus.magic_button, 1'b1);
    cross_tick();
    chk("to_still_held", bus.magic_button, 1'b1);
    chk("to_not_yet", bus.timeout, 1'b0);
    cross_tick();
    chk("to_magic_drop", bus.magic_button, 1'b0);
    chk("to_pause_low", bus.pause_button, 1'b0);
    chk("to_sticky", bus.timeout, 1'b1);
    chk("to_idle", bus.busy, 1'b0);
    chk_src("to_src", bus.req_src, SRC_NONE);

    // Next press clears timeout; magic_mode already set skips the request
    bus.magic_mode = 1'b1;
    bus.pause_btn_raw = 1'b1;
    repeat (6) step();
    chk("to_kept", bus.timeout, 1'b1);
    step();
    chk("to_cleared", bus.timeout, 1'b0);
    step();
    chk("skip_busy", bus.busy, 1'b1);
    chk("skip_no_req", bus.pause_button, 1'b0);
    bus.pause_btn_raw = 1'b0;
    bus.magic_mode = 1'b0;
    repeat (7) step();
    chk("skip_idle", bus.busy, 1'b0);

    // Long press
    cross_tick();
    reboots = 0;
    bus.magic_mode = 1'b1;
    bus.magic_btn_raw = 1'b1;
    repeat (7) step();
    cross_tick();
    chk("lp_f1", bus.reboot_req, 1'b0);
    cross_tick();
    chk("lp_f2", bus.reboot_req, 1'b0);
    cross_tick();
    chk("lp_f3", bus.reboot_req, 1'b1);
    cross_tick();
    chk("lp_once", reboots == 1, 1'b1);
    bus.magic_btn_raw = 1'b0;
    bus.magic_mode = 1'b0;
    repeat (8) step();
    chk("lp_idle", bus.busy, 1'b0);

    // Asynchronous reset mid-ASSERT
    cross_tick();
    bus.pause_btn_raw = 1'b1;
    repeat (7) step();
    bus.pause_btn_raw = 1'b0;
    cross_tick();
    chk("rst_pre_assert", bus.pause_button, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pause_button", bus.pause_button, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk_src("arst_src", bus.req_src, SRC_NONE);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_after", bus.busy, 1'b0);

    // Random button traffic against the debounce model
    repeat (120) begin
      bus.magic_btn_raw = 1'($urandom_range(0, 1));
      bus.pause_btn_raw = 1'($urandom_range(0, 1));
      bus.div_paged     = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/magic_nmi_ctrl.md
Name: magic_nmi_ctrl

Overview:
- Front-end controller for the magic/pause NMI machinery; sits between the raw board buttons and the magic-ROM entry logic.
- Synchronises and debounces both buttons and arbitrates between them, magic wins.
- Issues one clean request level per press, aligned to a frame boundary and withheld while DivMMC is paged or magic mode is already active.
- Supervises the entry handshake with a timeout, and detects a long magic press as a reboot request.

Parameters:
- DEBOUNCE_CYCLES, 28000: clk28 cycles a synchronised input must stay stable before its debounced level changes (1 ms).
- DEBOUNCE_W, 15: width of the debounce counter; must hold DEBOUNCE_CYCLES-1.
- LONG_PRESS_FRAMES, 100: frames magic must be held (debounced) before reboot_req fires.
- TIMEOUT_FRAMES, 8: frames ASSERT may last without magic_mode rising before the request is abandoned.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- magic_btn_raw  in  1  magic button, active-high, asynchronous
- pause_btn_raw  in  1  pause button, active-high, asynchronous
- n_int  in  1  frame interrupt, current value
- n_int_next  in  1  frame interrupt, next-cycle value
- div_paged  in  1  DivMMC memory currently paged in
- magic_mode  in  1  magic mode active; serves as the acknowledge
- magic_button  out  1  request level to the magic logic (magic source)
- pause_button  out  1  request level to the magic logic (pause source)
- magic_db  out  1  debounced magic button level, for status readback
- pause_db  out  1  debounced pause button level, for status readback
- req_src  out  2  magic_src_t of the pending or active request
- reboot_req  out  1  one-cycle pulse on a long press
- busy  out  1  state != IDLE
- timeout  out  1  sticky; set when a request is abandoned

Behaviour:
- Reset (asynchronous, active-low, any state):
  - FSM goes to IDLE.
  - All outputs are 0; req_src is SRC_NONE.
  - Synchronisers, debounce counters and frame counters are cleared.
- frame_tick = n_int && !n_int_next. It is one clk28 cycle per frame and is the only frame timebase.
- Debounce, per button:
  - Input passes through a 2-flop synchroniser.
  - If the synchronised value differs from db, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, db takes the synchronised value and the counter clears.
  - Latency from a stable raw change to db change is DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no db change.
- Press event: a rising edge of db, registered, one cycle wide.
- FSM IDLE:
  - On a magic press, latch SRC_MAGIC and go to PENDING.
  - Otherwise, on a pause press, latch SRC_PAUSE and go to PENDING.
  - If both press in the same cycle, magic is taken and the pause press is discarded.
- FSM PENDING:
  - On frame_tick && !div_paged && !magic_mode, go to ASSERT and clear the frame counter.
  - If magic_mode is already 1, go straight to WAIT_EXIT with no request issued.
  - A magic press while SRC_PAUSE is latched upgrades req_src to SRC_MAGIC.
- FSM ASSERT:
  - The output matching req_src is 1: magic_button for SRC_MAGIC, pause_button for SRC_PAUSE.
  - The output is held while the frame counter increments on each frame_tick.
  - When magic_mode = 1, both outputs drop in the same cycle and the FSM goes to WAIT_EXIT.
  - When the frame counter reaches TIMEOUT_FRAMES, both outputs drop, timeout is set and the FSM goes to IDLE.
- FSM WAIT_EXIT:
  - Go to IDLE once magic_mode = 0 and magic_db = 0 and pause_db = 0.
  - Presses seen in this state are ignored, so no re-entry on held buttons.
- req_src is valid from PENDING through WAIT_EXIT and returns to SRC_NONE in IDLE.
- timeout clears on the next press event or on reset.
- Long press, independent of the FSM:
  - The frame counter increments on frame_tick while magic_db = 1 and saturates at LONG_PRESS_FRAMES.
  - It clears when magic_db = 0.
  - reboot_req pulses once, in the cycle the count reaches LONG_PRESS_FRAMES; it fires only once per press.
- Only one request output is 1 at a time, and only in ASSERT.

Decomposition:
- Package common gets typedef enum logic [1:0] magic_src_t {SRC_NONE, SRC_MAGIC, SRC_PAUSE}.
- The FSM state enum is local to the module.
- Sub-module button_debounce (synchroniser, counter, db register, press pulse; parameters DEBOUNCE_CYCLES and DEBOUNCE_W), instantiated twice.

Test Plan:
- All cases use DEBOUNCE_CYCLES=4, LONG_PRESS_FRAMES=3, TIMEOUT_FRAMES=2 and a frame period of 50 cycles.
- Debounce: raw magic pulse of 3 cycles → magic_db stays 0. Raw held → magic_db = 1 exactly 6 cycles after the rise.
- Normal entry: magic pressed, div_paged=0 → magic_button = 1 in the cycle after the next frame_tick, req_src = SRC_MAGIC. Then magic_mode raised → magic_button = 0 in the same cycle and the FSM is in WAIT_EXIT. Then release and magic_mode=0 → busy = 0.
- Deferral: pause pressed with div_paged=1 across two frame_ticks → pause_button stays 0. div_paged drops → pause_button = 1 after the next frame_tick.
- Arbitration: magic and pause raw rise together → req_src = SRC_MAGIC and pause_button is never 1. Pause first, then magic during PENDING → req_src upgrades to SRC_MAGIC.
- Timeout: request asserted with magic_mode held 0 → after 2 frame_ticks both outputs are 0, timeout = 1, FSM in IDLE. The next press clears timeout.
- Long press and reset: magic held for 3 frame_ticks → exactly one reboot_req pulse. Asserting rst_n=0 mid-ASSERT → all outputs are 0 asynchronously and the FSM is in IDLE after release.
